// File: rtl/window_integrator.sv
// window_integrator: per-channel windowed integration of the ADC sample
// stream. Each triggered window sums a programmable number of sample sets
// per channel. The result is copied into an emit bank and sent out as one
// fixed-length 64-bit AXI-stream packet. Because the accumulators and the
// emit bank are separate, the next window can accumulate while the previous
// packet drains.
module window_integrator #(
    parameter int          NUM_CH    = 16,
    parameter int          WIDTH     = 18,
    parameter int          SUM_WIDTH = 40,
    parameter logic [7:0]  PKT_ID    = 8'hA0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          start,
    input  logic [15:0]                   num_samples,
    input  logic [63:0]                   in_timestamp,
    input  logic                          sample_valid,
    input  logic [NUM_CH-1:0]             sample_ch_valid,
    input  logic [NUM_CH-1:0][WIDTH-1:0]  sample_ch_data,
    output logic [63:0]                   fifo_tdata,
    output logic                          fifo_tvalid,
    output logic                          fifo_tlast,
    input  logic                          fifo_tready,
    output logic                          busy,
    output logic [23:0]                   window_seq,
    output logic [15:0]                   overrun_count
);

    // Catch parameter sets for which the sums could overflow or the
    // channel number no longer fits its header byte.
    if (SUM_WIDTH < WIDTH + 16) begin : g_bad_sum_width
        $error("window_integrator: SUM_WIDTH must be >= WIDTH+16");
    end
    if (NUM_CH < 1 || NUM_CH > 255) begin : g_bad_num_ch
        $error("window_integrator: NUM_CH must be in 1..255");
    end

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } acc_state_t;

    typedef enum logic [1:0] {
        E_IDLE,
        E_HDR,
        E_TS,
        E_CH
    } emit_state_t;

    // Accumulation side
    acc_state_t                         r_acc_state;
    acc_state_t                         w_acc_next;
    logic                               r_start_d;
    logic [15:0]                        r_target;
    logic [15:0]                        r_sample_cnt;
    logic [63:0]                        r_win_ts;
    logic [NUM_CH-1:0][SUM_WIDTH-1:0]   r_sum;
    logic [NUM_CH-1:0][15:0]            r_good;
    logic [23:0]                        r_window_seq;
    logic [15:0]                        r_overrun;

    // Emit bank
    logic                               r_bank_full;
    logic [NUM_CH-1:0][SUM_WIDTH-1:0]   r_bank_sum;
    logic [NUM_CH-1:0][15:0]            r_bank_good;
    logic [63:0]                        r_bank_ts;
    logic [15:0]                        r_bank_target;
    logic [23:0]                        r_bank_seq;

    // Emit side
    emit_state_t                        r_emit_state;
    emit_state_t                        w_emit_next;
    logic [IDX_W-1:0]                   r_ch_idx;
    logic [IDX_W-1:0]                   w_ch_idx_next;

    logic                               w_start_edge;
    logic                               w_start_win;
    logic                               w_take;
    logic                               w_complete;
    logic                               w_emit_done;
    logic                               w_bank_free;
    logic [NUM_CH-1:0][SUM_WIDTH-1:0]   w_ext_data;
    logic [NUM_CH-1:0][SUM_WIDTH-1:0]   w_sum_upd;
    logic [NUM_CH-1:0][15:0]            w_good_upd;
    logic [NUM_CH-1:0][39:0]            w_sum40;
    logic [NUM_CH-1:0][63:0]            w_ch_word;
    logic [63:0]                        w_hdr_word;

    assign w_start_edge = start & ~r_start_d;

    // The bank counts as free in the cycle its last word is accepted, so a
    // window completing in that same cycle is not lost.
    assign w_bank_free = ~r_bank_full | w_emit_done;

    // Per-channel datapath: sign extension, the running sum including the
    // current sample, and the outgoing channel word built from the bank.
    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [7:0] CH_ID = 8'(gi);

        assign w_ext_data[gi] = {{(SUM_WIDTH - WIDTH){sample_ch_data[gi][WIDTH-1]}},
                                 sample_ch_data[gi]};
        assign w_sum_upd[gi]  = sample_ch_valid[gi] ? (r_sum[gi] + w_ext_data[gi]) : r_sum[gi];
        assign w_good_upd[gi] = sample_ch_valid[gi] ? (r_good[gi] + 16'd1) : r_good[gi];

        if (SUM_WIDTH >= 40) begin : g_trunc
            assign w_sum40[gi] = r_bank_sum[gi][39:0];
        end else begin : g_sext
            assign w_sum40[gi] = {{(40 - SUM_WIDTH){r_bank_sum[gi][SUM_WIDTH-1]}}, r_bank_sum[gi]};
        end

        assign w_ch_word[gi] = {CH_ID, r_bank_good[gi], w_sum40[gi]};
    end

    assign w_hdr_word = {PKT_ID, r_bank_seq, r_bank_target, 8'(NUM_CH), 8'h00};

    // Accumulate FSM next state: start on a qualified edge, abort on ena low,
    // finish on the sample that reaches the latched target.
    always_comb begin
        w_acc_next  = r_acc_state;
        w_start_win = 1'b0;
        w_take      = 1'b0;
        w_complete  = 1'b0;
        unique case (r_acc_state)
            S_IDLE: begin
                if (w_start_edge && ena) begin
                    w_acc_next  = S_ACCUM;
                    w_start_win = 1'b1;
                end
            end
            S_ACCUM: begin
                if (!ena) begin
                    w_acc_next = S_IDLE;
                end else if (sample_valid) begin
                    w_take = 1'b1;
                    if (({1'b0, r_sample_cnt} + 17'd1) == {1'b0, r_target}) begin
                        w_complete = 1'b1;
                        w_acc_next = S_IDLE;
                    end
                end
            end
            default: w_acc_next = S_IDLE;
        endcase
    end

    // Accumulators, bank loading and the window/overrun counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_state   <= S_IDLE;
            r_start_d     <= 1'b1;
            r_target      <= '0;
            r_sample_cnt  <= '0;
            r_win_ts      <= '0;
            r_sum         <= '0;
            r_good        <= '0;
            r_window_seq  <= '0;
            r_overrun     <= '0;
            r_bank_full   <= 1'b0;
            r_bank_sum    <= '0;
            r_bank_good   <= '0;
            r_bank_ts     <= '0;
            r_bank_target <= '0;
            r_bank_seq    <= '0;
        end else begin
            r_acc_state <= w_acc_next;
            r_start_d   <= start;

            if (w_start_win) begin
                r_target     <= (num_samples == 16'd0) ? 16'd1 : num_samples;
                r_sum        <= '0;
                r_good       <= '0;
                r_sample_cnt <= '0;
            end else if (w_take) begin
                r_sum        <= w_sum_upd;
                r_good       <= w_good_upd;
                r_sample_cnt <= r_sample_cnt + 16'd1;
                if (r_sample_cnt == 16'd0) begin
                    r_win_ts <= in_timestamp;
                end
            end

            if (w_complete && w_bank_free) begin
                r_bank_sum    <= w_sum_upd;
                r_bank_good   <= w_good_upd;
                r_bank_ts     <= (r_sample_cnt == 16'd0) ? in_timestamp : r_win_ts;
                r_bank_target <= r_target;
                r_bank_seq    <= r_window_seq;
                r_window_seq  <= r_window_seq + 24'd1;
                r_bank_full   <= 1'b1;
            end else begin
                if (w_emit_done) begin
                    r_bank_full <= 1'b0;
                end
                if (w_complete && (r_overrun != 16'hFFFF)) begin
                    r_overrun <= r_overrun + 16'd1;
                end
            end
        end
    end

    // Emit FSM next state and stream outputs; the word is a pure function of
    // state and bank, so it holds steady while the sink stalls.
    always_comb begin
        w_emit_next   = r_emit_state;
        w_ch_idx_next = r_ch_idx;
        w_emit_done   = 1'b0;
        fifo_tdata    = '0;
        fifo_tvalid   = 1'b0;
        fifo_tlast    = 1'b0;
        unique case (r_emit_state)
            E_IDLE: begin
                if (r_bank_full) begin
                    w_emit_next = E_HDR;
                end
            end
            E_HDR: begin
                fifo_tdata  = w_hdr_word;
                fifo_tvalid = 1'b1;
                if (fifo_tready) begin
                    w_emit_next = E_TS;
                end
            end
            E_TS: begin
                fifo_tdata  = r_bank_ts;
                fifo_tvalid = 1'b1;
                if (fifo_tready) begin
                    w_emit_next   = E_CH;
                    w_ch_idx_next = '0;
                end
            end
            E_CH: begin
                fifo_tdata  = w_ch_word[r_ch_idx];
                fifo_tvalid = 1'b1;
                fifo_tlast  = (r_ch_idx == LAST_IDX);
                if (fifo_tready) begin
                    if (r_ch_idx == LAST_IDX) begin
                        w_emit_next   = E_IDLE;
                        w_ch_idx_next = '0;
                        w_emit_done   = 1'b1;
                    end else begin
                        w_ch_idx_next = r_ch_idx + IDX_W'(1);
                    end
                end
            end
            default: w_emit_next = E_IDLE;
        endcase
    end

    // Emit FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_emit_state <= E_IDLE;
            r_ch_idx     <= '0;
        end else begin
            r_emit_state <= w_emit_next;
            r_ch_idx     <= w_ch_idx_next;
        end
    end

    assign busy          = (r_acc_state == S_ACCUM);
    assign window_seq    = r_window_seq;
    assign overrun_count = r_overrun;

endmodule
